// File: rtl/tank_video_pkg.sv
// Shared constants and types for the tank video path.
// Tile geometry, memory widths and the background fetch states.
package tank_video_pkg;

  localparam int TILE_W   = 8;
  localparam int MAP_COLS = 32;
  localparam int MAP_ROWS = 32;
  localparam int VRAM_AW  = 11;
  localparam int CROM_AW  = 11;

  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = $clog2(MAP_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    VWAIT,
    VDATA,
    RWAIT,
    RDATA
  } fetch_state_t;

  // Map offset of the tile one column ahead of the beam.
  // The column increment wraps inside the 32-column map.
  function automatic logic [ROW_W+COL_W-1:0] tile_index(
    input logic [COL_W-1:0] cur_col,
    input logic [ROW_W-1:0] row
  );
    logic [COL_W-1:0] col;
    col = cur_col + COL_W'(1);
    return {row, col};
  endfunction

endpackage

// File: rtl/tank_bg_fetch_if.sv
// Read bus from the background fetch engine to video RAM and char ROM.
// Both memories return data one clk after the address is sampled.
interface tank_bg_fetch_if;
  import tank_video_pkg::*;

  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we_n;
  logic [7:0]         vram_q;
  logic [CROM_AW-1:0] rom_addr;
  logic [7:0]         rom_q;

  modport master (
    output vram_addr,
    output vram_we_n,
    output rom_addr,
    input  vram_q,
    input  rom_q
  );

  modport slave (
    input  vram_addr,
    input  vram_we_n,
    input  rom_addr,
    output vram_q,
    output rom_q
  );

endinterface

// File: rtl/bg_shift8.sv
// 8-pixel load/shift register for one tile row, MSB out first.
// Output pixel is registered and forced to 0 during blanking.
module bg_shift8
  import tank_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              load,
  input  logic [TILE_W-1:0] din,
  input  logic              blank,
  output logic              pix
);

  logic [TILE_W-1:0] sh;

  // Load a new row or shift; pix takes the pre-update MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      pix <= 1'b0;
    end else if (ce) begin
      if (load) sh <= din;
      else      sh <= {sh[TILE_W-2:0], 1'b0};
      pix <= blank ? 1'b0 : sh[TILE_W-1];
    end
  end

endmodule

// File: rtl/tank_bg_fetch.sv
// Background tile fetch: tile code from VRAM, row from char ROM,
// then handed to the shifter at the end of the current tile column.
module tank_bg_fetch
  import tank_video_pkg::*;
#(
  parameter logic [VRAM_AW-1:0] ROW_BASE = 11'h000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_ce,
  input  logic [8:0]      hcnt,
  input  logic [8:0]      vcnt,
  input  logic            blank,
  tank_bg_fetch_if.master bus,
  output logic            pix,
  output logic            overrun
);

  fetch_state_t      state;
  logic [TILE_W-1:0] next_buf;
  logic              next_valid;

  logic              req;
  logic              load;
  logic [TILE_W-1:0] load_val;
  logic [9:0]        tile;
  logic              unused_bits;

  assign req  = pix_ce && (hcnt[2:0] == 3'd0) && !blank;
  assign load = pix_ce && (hcnt[2:0] == 3'd7);

  assign load_val = next_valid ? next_buf : '0;
  assign tile     = tile_index(hcnt[7:3], vcnt[7:3]);

  assign bus.vram_we_n = 1'b1;
  assign unused_bits   = ^{hcnt[8], vcnt[8]};

  // Fetch sequencer; the shifter load consumes next_buf.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.vram_addr <= '0;
      bus.rom_addr  <= '0;
      next_buf      <= '0;
      next_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (req && state != IDLE) overrun <= 1'b1;
      if (load) next_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            bus.vram_addr <= ROW_BASE + {1'b0, tile};
            state         <= VWAIT;
          end
        end
        VWAIT: state <= VDATA;
        VDATA: begin
          bus.rom_addr <= {bus.vram_q, vcnt[2:0]};
          state        <= RWAIT;
        end
        RWAIT: state <= RDATA;
        RDATA: begin
          next_buf   <= bus.rom_q;
          next_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bg_shift8 u_shift (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce),
    .load  (load),
    .din   (load_val),
    .blank (blank),
    .pix   (pix)
  );

endmodule

// File: tb/tb_tank_bg_fetch.sv
// Directed bench for tank_bg_fetch with behavioural VRAM/ROM.
// Each task drives one scenario and checks against hand values.
module tb_tank_bg_fetch;
  import tank_video_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       blank;
  logic       pix;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] vram [0:2047];
  logic [7:0] rom  [0:2047];
  logic [7:0] pat;

  tank_bg_fetch_if bus ();

  tank_bg_fetch #(.ROW_BASE(11'h000)) dut (
    .clk     (clk),
    .reset   (reset),
    .pix_ce  (pix_ce),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .blank   (blank),
    .bus     (bus.master),
    .pix     (pix),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.vram_q <= vram[bus.vram_addr];
    bus.rom_q  <= rom[bus.rom_addr];
  end

  task automatic tick(input logic [8:0] h);
    hcnt   = h;
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pix_ce = 1'b0;
    hcnt   = 9'd0;
    blank  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vcnt = 9'h00D;
    tick(9'h010);
    tick(9'h011);
    tick(9'h010);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(9'h012 + 9'(i));
      checks++;
      if (pix !== 1'b0) begin
        errors++;
        $display("FAIL reset_pix: got %b want 0", pix);
      end
      checks++;
      if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_overrun: got %b want 0", overrun);
      end
      checks++;
      if (bus.vram_we_n !== 1'b1) begin
        errors++;
        $display("FAIL reset_we_n: got %b want 1", bus.vram_we_n);
      end
    end
    checks++;
    if (bus.vram_addr !== 11'h000) begin
      errors++;
      $display("FAIL reset_vram_addr: got %h want 000", bus.vram_addr);
    end
    checks++;
    if (bus.rom_addr !== 11'h000) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h want 000", bus.rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    vcnt = 9'h00D;
    pat  = 8'hA5;
    for (int h = 9'h010; h <= 9'h01F; h++) begin
      tick(9'(h));
      if (h == 9'h010) begin
        checks++;
        if (bus.vram_addr !== 11'h023) begin
          errors++;
          $display("FAIL single_vram_addr: got %h want 023", bus.vram_addr);
        end
      end
      if (h == 9'h012) begin
        checks++;
        if (bus.rom_addr !== 11'h20D) begin
          errors++;
          $display("FAIL single_rom_addr: got %h want 20d", bus.rom_addr);
        end
      end
      if (h >= 9'h018) begin
        checks++;
        if (pix !== pat[7 - (h - 9'h018)]) begin
          errors++;
          $display("FAIL single_pix h=%h: got %b want %b",
                   h, pix, pat[7 - (h - 9'h018)]);
        end
      end
    end
  endtask

  task automatic test_col_wrap();
    do_reset();
    vcnt = 9'h000;
    tick(9'h0F0);
    checks++;
    if (bus.vram_addr !== 11'h01F) begin
      errors++;
      $display("FAIL wrap_col31: got %h want 01f", bus.vram_addr);
    end
    for (int h = 9'h0F1; h <= 9'h0F7; h++) tick(9'(h));
    tick(9'h0F8);
    checks++;
    if (bus.vram_addr !== 11'h000) begin
      errors++;
      $display("FAIL wrap_col0: got %h want 000", bus.vram_addr);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    vcnt = 9'h00D;
    pat  = 8'hA5;
    tick(9'h010);
    tick(9'h011);
    tick(9'h020);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    checks++;
    if (bus.vram_addr !== 11'h023) begin
      errors++;
      $display("FAIL overrun_addr: got %h want 023", bus.vram_addr);
    end
    for (int h = 9'h013; h <= 9'h017; h++) tick(9'(h));
    for (int h = 9'h018; h <= 9'h01F; h++) begin
      tick(9'(h));
      checks++;
      if (pix !== pat[7 - (h - 9'h018)]) begin
        errors++;
        $display("FAIL overrun_pix h=%h: got %b want %b",
                 h, pix, pat[7 - (h - 9'h018)]);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_blank();
    do_reset();
    vcnt  = 9'h00D;
    blank = 1'b1;
    for (int h = 9'h010; h <= 9'h017; h++) begin
      tick(9'(h));
      checks++;
      if (bus.vram_addr !== 11'h000) begin
        errors++;
        $display("FAIL blank_addr h=%h: got %h want 000", h, bus.vram_addr);
      end
    end
    blank = 1'b0;
    for (int h = 9'h018; h <= 9'h01F; h++) begin
      tick(9'(h));
      checks++;
      if (pix !== 1'b0) begin
        errors++;
        $display("FAIL blank_empty_pix h=%h: got %b want 0", h, pix);
      end
    end
    blank = 1'b1;
    for (int h = 9'h020; h <= 9'h027; h++) begin
      tick(9'(h));
      checks++;
      if (pix !== 1'b0) begin
        errors++;
        $display("FAIL blank_gate_pix h=%h: got %b want 0", h, pix);
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    vcnt = 9'h00D;
    tick(9'h010);
    tick(9'h011);
    reset = 1'b1;
    tick(9'h012);
    reset = 1'b0;
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL midrst_state: got %0d want %0d", dut.state, IDLE);
    end
    checks++;
    if (dut.next_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b want 0", dut.next_valid);
    end
    checks++;
    if (bus.rom_addr !== 11'h000) begin
      errors++;
      $display("FAIL midrst_rom_addr: got %h want 000", bus.rom_addr);
    end
    for (int h = 9'h013; h <= 9'h017; h++) tick(9'(h));
    for (int h = 9'h018; h <= 9'h01F; h++) begin
      tick(9'(h));
      checks++;
      if (pix !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pix h=%h: got %b want 0", h, pix);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'h00;
      rom[i]  = 8'h00;
    end
    vram[11'h023] = 8'h41;
    vram[11'h024] = 8'h41;
    rom[11'h20D]  = 8'hA5;
    reset  = 1'b1;
    pix_ce = 1'b0;
    hcnt   = 9'd0;
    vcnt   = 9'd0;
    blank  = 1'b0;
    test_reset();
    test_single_fetch();
    test_col_wrap();
    test_overrun();
    test_blank();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
